// File: rtl/register_file.sv
// 32-entry RISC-V general-purpose register file: two combinational read ports,
// one synchronous write port, hardwired-zero x0 and optional write-to-read bypass.
module register_file #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   rd_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            reg_write,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data
);

    logic [NREGS-1:0] load_en_s;
    logic [XLEN-1:0]  entry_s [NREGS];
    logic             wr_valid_s;

    // A write is only live out of reset and never targets x0.
    assign wr_valid_s = rst & reg_write & (rd_addr != {AW{1'b0}});

    // Decode one load enable per architectural register.
    always_comb begin
        load_en_s = {NREGS{1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            if (wr_valid_s && (rd_addr == AW'(i))) begin
                load_en_s[i] = 1'b1;
            end else begin
                load_en_s[i] = 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NREGS; g++) begin : gen_entry
            if (g == 0) begin : gen_zero
                assign entry_s[g] = {XLEN{1'b0}};
            end else begin : gen_reg
                logic [XLEN-1:0] q_r;

                // Load-enabled storage element, cleared asynchronously.
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        q_r <= {XLEN{1'b0}};
                    end else if (load_en_s[g]) begin
                        q_r <= wr_data;
                    end else begin
                        q_r <= q_r;
                    end
                end

                assign entry_s[g] = q_r;
            end
        end
    endgenerate

    // Bypass compares addresses only, so no path runs from wr_data through storage back to a read.
    function automatic logic [XLEN-1:0] read_port(
        input logic            rst_v,
        input logic [AW-1:0]   addr,
        input logic            wr_valid,
        input logic [AW-1:0]   waddr,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] stored
    );
        logic [XLEN-1:0] value;
        if (!rst_v) begin
            value = {XLEN{1'b0}};
        end else if (addr == {AW{1'b0}}) begin
            value = {XLEN{1'b0}};
        end else if ((BYPASS != 0) && wr_valid && (waddr == addr)) begin
            value = wdata;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Combinational read ports with x0 forcing and optional forwarding.
    always_comb begin
        rs1_data = read_port(rst, rs1_addr, wr_valid_s, rd_addr, wr_data, entry_s[rs1_addr]);
        rs2_data = read_port(rst, rs2_addr, wr_valid_s, rd_addr, wr_data, entry_s[rs2_addr]);
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized self-checking bench for register_file; runs bypass and non-bypass builds
// side by side against an array-based architectural model.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic        reg_write;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] rs1_data_nb;
    logic [31:0] rs2_data_nb;

    logic [31:0] model [32];
    int          n_checks;
    int          n_fail;

    register_file #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .wr_data(wr_data), .reg_write(reg_write),
        .rs1_data(rs1_data), .rs2_data(rs2_data)
    );

    register_file #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .wr_data(wr_data), .reg_write(reg_write),
        .rs1_data(rs1_data_nb), .rs2_data(rs2_data_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Architectural read: write-first when forwarding, old value otherwise.
    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (rst !== 1'b1) return 32'h0;
        if (a == 5'd0) return 32'h0;
        if (byp && reg_write && (rd_addr == a)) return wr_data;
        return model[a];
    endfunction

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        reg_write = we;
        rd_addr   = rd;
        wr_data   = wd;
        rs1_addr  = a1;
        rs2_addr  = a2;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst && reg_write && (rd_addr != 5'd0)) model[rd_addr] = wr_data;
        #1;
    endtask

    task automatic check_reads(input string tag);
        #1;
        check_value({tag, "_rs1"},    rs1_data,    exp_read(rs1_addr, 1'b1));
        check_value({tag, "_rs2"},    rs2_data,    exp_read(rs2_addr, 1'b1));
        check_value({tag, "_rs1_nb"}, rs1_data_nb, exp_read(rs1_addr, 1'b0));
        check_value({tag, "_rs2_nb"}, rs2_data_nb, exp_read(rs2_addr, 1'b0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst = 1'b0;
        drive(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd0);

        // Reset state: writes and bypass suppressed.
        check_value("rst_bypass_rs1", rs1_data, 32'h0);
        check_value("rst_bypass_nb", rs1_data_nb, 32'h0);
        tick();
        check_reads("rst_hold");
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        check_value("rst_no_write", rs1_data, 32'h0);

        // Asynchronous reset mid-cycle.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
        check_value("preload_x5", rs1_data, 32'hDEADBEEF);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_value("async_rst_x5", rs1_data, 32'h0);
        check_value("async_rst_x5_nb", rs1_data_nb, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'(31 - i);
            check_reads("post_rst");
        end

        // Write then read on both ports.
        @(negedge clk);
        drive(1'b1, 5'd7, 32'h12345678, 5'd6, 5'd8);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
        #1;
        check_value("wr_x7_rs1", rs1_data, 32'h12345678);
        check_value("wr_x7_rs2", rs2_data, 32'h12345678);
        rs1_addr = 5'd6;
        rs2_addr = 5'd8;
        #1;
        check_value("x6_zero", rs1_data, 32'h0);
        check_value("x8_zero", rs2_data, 32'h0);

        // x0 protection, including with bypass conditions held.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        check_value("x0_bypass", rs1_data, 32'h0);
        tick();
        #1;
        check_value("x0_after", rs1_data, 32'h0);
        check_value("x0_after_rs2", rs2_data, 32'h0);

        // Bypass vs. no-bypass.
        drive(1'b1, 5'd3, 32'h00000011, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd4, 32'h00000044, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd3, 32'h00000022, 5'd3, 5'd4);
        #1;
        check_value("byp_rs1", rs1_data, 32'h00000022);
        check_value("byp_rs2", rs2_data, 32'h00000044);
        check_value("nobyp_rs1", rs1_data_nb, 32'h00000011);
        rs2_addr = 5'd3;
        #1;
        check_value("byp_both", rs2_data, 32'h00000022);
        tick();
        reg_write = 1'b0;
        #1;
        check_value("byp_after", rs1_data, 32'h00000022);
        check_value("nobyp_after", rs1_data_nb, 32'h00000022);

        // Back-to-back writes.
        drive(1'b1, 5'd1, 32'h1, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd2, 32'h2, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd31, 32'hA5A5A5A5, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd1, 32'h77, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
        #1;
        check_value("b2b_x1", rs1_data, 32'h77);
        check_value("b2b_x2", rs2_data, 32'h2);
        rs1_addr = 5'd31;
        #1;
        check_value("b2b_x31", rs1_data, 32'hA5A5A5A5);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 7) == 0) rs2_addr = rd_addr;
            if ($urandom_range(0, 7) == 0) rs1_addr = rd_addr;
            check_reads("rand");
            tick();
        end

        // Full sweep of stored state.
        reg_write = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i);
            rs2_addr = 5'($urandom_range(0, 31));
            check_reads("sweep");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
